rv_mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the RV32I core's instruction-fetch path and its load/store path. Requests are served one at a time through a 3-state FSM, with data priority and a per-access timeout watchdog. A combinational stall is returned to the core so the PC and pipeline hold while an access is pending. Sits between RISCV_Processor and the memory model/BRAM wrapper.

---
 rtl/rv_mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_rv_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_port_arbiter.sv
// Single-port memory arbiter between RV32I fetch and load/store paths, data-first priority,
// per-access timeout watchdog. Optional performance counters under `MEM_ARB_PERF_EN`.
module rv_mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_done,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                d_err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                core_stall
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_i_grants,
   output logic [31:0]         perf_d_grants,
   output logic [31:0]         perf_stall_cycles
`endif
);

   // state | meaning
   // IDLE  | no access in flight; arbitrate (data before fetch)
   // IBUSY | fetch access on the memory port, waiting for mem_ready
   // DBUSY | load/store access on the memory port, waiting for mem_ready
   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

   state_t          state, state_nxt;
   logic [WD_W-1:0] wd_cnt;
   logic            grant_i, grant_d, finish, abort;

   assign core_stall = (i_req & ~i_done) | (d_req & ~d_done);

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !d_done) begin
               grant_d   = 1'b1;
               state_nxt = DBUSY;
            end else if (i_req && !i_done) begin
               grant_i   = 1'b1;
               state_nxt = IBUSY;
            end
         end
         IBUSY, DBUSY: begin
            // mem_ready wins over the terminal count on the same cycle
            if (mem_ready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end else if (wd_cnt == '0) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wd_cnt    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         i_rdata   <= '0;
         i_done    <= 1'b0;
         i_err     <= 1'b0;
         d_rdata   <= '0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         state  <= state_nxt;
         i_done <= 1'b0;
         i_err  <= 1'b0;
         d_done <= 1'b0;
         d_err  <= 1'b0;
         if (grant_d) begin
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            wd_cnt    <= WD_LOAD;
         end else if (grant_i) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_be    <= '1;
            wd_cnt    <= WD_LOAD;
         end else if (finish || abort) begin
            mem_en <= 1'b0;
            if (state == IBUSY) begin
               i_done <= 1'b1;
               i_err  <= abort;
               if (finish) i_rdata <= mem_rdata;
            end else begin
               d_done <= 1'b1;
               d_err  <= abort;
               if (finish && !mem_we) d_rdata <= mem_rdata;
            end
         end else if (state != IDLE) begin
            wd_cnt <= wd_cnt - 1'b1;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_i_grants     <= '0;
         perf_d_grants     <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (grant_i)    perf_i_grants     <= perf_i_grants + 1'b1;
         if (grant_d)    perf_d_grants     <= perf_d_grants + 1'b1;
         if (core_stall) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rv_mem_port_arbiter.sv
// Self-checking bench for rv_mem_port_arbiter: cycle table plus directed corner sequences.
module tb_rv_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, mem_ready;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_be;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_done, i_err, d_done, d_err, mem_en, mem_we, core_stall;
   logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_stall_cycles;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rv_mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .core_stall(core_stall)
`ifdef MEM_ARB_PERF_EN
      , .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   typedef struct {
      logic        rst, ireq, dreq, dwe, mready;
      logic [31:0] iaddr, daddr, mrdata;
      logic [3:0]  dbe;
      logic        en, we, idone, ddone, stall;
      logic [31:0] addr, irdata, drdata;
      logic [3:0]  be;
   } vec_t;

   function automatic vec_t v(input logic rst, ireq, input logic [31:0] iaddr,
                              input logic dreq, dwe, input logic [31:0] daddr,
                              input logic [3:0] dbe, input logic [31:0] mrdata,
                              input logic mready, en, we, input logic [31:0] addr,
                              input logic [3:0] be, input logic idone, ddone, stall,
                              input logic [31:0] irdata, drdata);
      vec_t r;
      r.rst = rst; r.ireq = ireq; r.iaddr = iaddr; r.dreq = dreq; r.dwe = dwe;
      r.daddr = daddr; r.dbe = dbe; r.mrdata = mrdata; r.mready = mready;
      r.en = en; r.we = we; r.addr = addr; r.be = be; r.idone = idone;
      r.ddone = ddone; r.stall = stall; r.irdata = irdata; r.drdata = drdata;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 1'b0;
   endtask

   vec_t tbl[14];
   int   n;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = v(1,1,32'h10, 0,0,0,0,         0,0, 0,0,0,0,        0,0,1, 0,0);
      tbl[1]  = v(1,1,32'h10, 0,0,0,0,         0,0, 0,0,0,0,        0,0,1, 0,0);
      tbl[2]  = v(0,1,32'h10, 0,0,0,0,         0,0, 0,0,0,0,        0,0,1, 0,0);
      tbl[3]  = v(0,1,32'h10, 0,0,0,0, 32'h00500093,1, 1,0,32'h10,4'hf, 0,0,1, 0,0);
      tbl[4]  = v(0,1,32'h10, 0,0,0,0,         0,0, 0,0,32'h10,4'hf, 1,0,0, 32'h00500093,0);
      tbl[5]  = v(0,0,0,      0,0,0,0,         0,0, 0,0,32'h10,4'hf, 0,0,0, 32'h00500093,0);
      tbl[6]  = v(0,1,32'h20, 1,0,32'h100,4'hf, 0,0, 0,0,32'h10,4'hf, 0,0,1, 32'h00500093,0);
      tbl[7]  = v(0,1,32'h20, 1,0,32'h100,4'hf, 32'hDEADBEEF,1, 1,0,32'h100,4'hf, 0,0,1,
                  32'h00500093,0);
      tbl[8]  = v(0,1,32'h20, 1,0,32'h100,4'hf, 0,0, 0,0,32'h100,4'hf, 0,1,1,
                  32'h00500093,32'hDEADBEEF);
      tbl[9]  = v(0,1,32'h20, 0,0,0,0, 0,0, 1,0,32'h20,4'hf, 0,0,1, 32'h00500093,32'hDEADBEEF);
      tbl[10] = v(0,1,32'h20, 0,0,0,0, 32'h11111111,1, 1,0,32'h20,4'hf, 0,0,1,
                  32'h00500093,32'hDEADBEEF);
      tbl[11] = v(0,1,32'h20, 0,0,0,0, 0,0, 0,0,32'h20,4'hf, 1,0,0, 32'h11111111,32'hDEADBEEF);
      tbl[12] = v(0,0,0, 0,0,0,0, 32'h00000BAD,1, 0,0,32'h20,4'hf, 0,0,0,
                  32'h11111111,32'hDEADBEEF);
      tbl[13] = v(0,0,0, 0,0,0,0, 0,0, 0,0,32'h20,4'hf, 0,0,0, 32'h11111111,32'hDEADBEEF);

      idle_inputs();
      reset = 1'b1;
      step();

      foreach (tbl[i]) begin
         reset = tbl[i].rst; i_req = tbl[i].ireq; i_addr = tbl[i].iaddr;
         d_req = tbl[i].dreq; d_we = tbl[i].dwe; d_addr = tbl[i].daddr; d_be = tbl[i].dbe;
         mem_rdata = tbl[i].mrdata; mem_ready = tbl[i].mready;
         #4;
         chk($sformatf("r%0d mem_en", i),     {31'b0, mem_en},     {31'b0, tbl[i].en});
         chk($sformatf("r%0d mem_we", i),     {31'b0, mem_we},     {31'b0, tbl[i].we});
         chk($sformatf("r%0d mem_addr", i),   mem_addr,            tbl[i].addr);
         chk($sformatf("r%0d mem_be", i),     {28'b0, mem_be},     {28'b0, tbl[i].be});
         chk($sformatf("r%0d i_done", i),     {31'b0, i_done},     {31'b0, tbl[i].idone});
         chk($sformatf("r%0d d_done", i),     {31'b0, d_done},     {31'b0, tbl[i].ddone});
         chk($sformatf("r%0d errs", i),       {30'b0, i_err, d_err}, 32'd0);
         chk($sformatf("r%0d core_stall", i), {31'b0, core_stall}, {31'b0, tbl[i].stall});
         chk($sformatf("r%0d i_rdata", i),    i_rdata,             tbl[i].irdata);
         chk($sformatf("r%0d d_rdata", i),    d_rdata,             tbl[i].drdata);
         step();
      end
      idle_inputs();

      // store with 3-cycle memory latency
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'b0011;
      step();
      for (int k = 1; k <= 3; k++) begin
         mem_ready = (k == 3);
         #4;
         chk($sformatf("st%0d mem_en", k),    {31'b0, mem_en}, 32'd1);
         chk($sformatf("st%0d mem_we", k),    {31'b0, mem_we}, 32'd1);
         chk($sformatf("st%0d mem_be", k),    {28'b0, mem_be}, 32'h3);
         chk($sformatf("st%0d mem_addr", k),  mem_addr, 32'h200);
         chk($sformatf("st%0d mem_wdata", k), mem_wdata, 32'h12345678);
         chk($sformatf("st%0d d_done", k),    {31'b0, d_done}, 32'd0);
         step();
      end
      mem_ready = 0;
      #4;
      chk("st d_done", {31'b0, d_done}, 32'd1);
      chk("st d_err",  {31'b0, d_err},  32'd0);
      chk("st mem_en", {31'b0, mem_en}, 32'd0);
      chk("st d_rdata_kept", d_rdata, 32'hDEADBEEF);
      d_req = 0;
      step();

      // data timeout: mem_ready never comes
      d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hf;
      step();
      n = 0;
      #4;
      while (mem_en && n < 40) begin
         if (d_done) begin
            tests++; fails++;
            $display("FAIL to early_done: got d_done=1 at busy cycle %0d expected 0", n);
         end
         n++;
         step();
         #4;
      end
      chk("to busy_cycles", n, 32'd16);
      chk("to d_done", {31'b0, d_done}, 32'd1);
      chk("to d_err",  {31'b0, d_err},  32'd1);
      chk("to d_rdata_kept", d_rdata, 32'hDEADBEEF);
      d_req = 0;
      step();

      // fetch completing on the terminal watchdog cycle, then re-request right after done
      i_req = 1; i_addr = 32'h40;
      step();
      for (int k = 1; k <= 16; k++) begin
         mem_ready = (k == 16);
         mem_rdata = (k == 16) ? 32'hCAFE0001 : 32'h0;
         #4;
         chk($sformatf("tc%0d mem_en", k), {31'b0, mem_en}, 32'd1);
         step();
      end
      mem_ready = 0;
      #4;
      chk("tc i_done", {31'b0, i_done}, 32'd1);
      chk("tc i_err",  {31'b0, i_err},  32'd0);
      chk("tc i_rdata", i_rdata, 32'hCAFE0001);
      step();
      #4;
      chk("rr idle_after_done", {31'b0, mem_en}, 32'd0);
      step();
      mem_ready = 1; mem_rdata = 32'hCAFE0002;
      #4;
      chk("rr regrant mem_en", {31'b0, mem_en}, 32'd1);
      step();
      mem_ready = 0;
      #4;
      chk("rr i_done", {31'b0, i_done}, 32'd1);
      chk("rr i_rdata", i_rdata, 32'hCAFE0002);
      i_req = 0;
      step();

      // reset mid-DBUSY, then a late mem_ready
      d_req = 1; d_addr = 32'h400; d_be = 4'hf;
      step();
      #4;
      chk("rb busy mem_en", {31'b0, mem_en}, 32'd1);
      reset = 1; d_req = 0;
      step();
      reset = 0; mem_ready = 1; mem_rdata = 32'h55555555;
      for (int k = 0; k < 3; k++) begin
         #4;
         chk($sformatf("rb%0d mem_en", k), {31'b0, mem_en}, 32'd0);
         chk($sformatf("rb%0d d_done", k), {31'b0, d_done}, 32'd0);
         chk($sformatf("rb%0d d_rdata", k), d_rdata, 32'd0);
`ifdef MEM_ARB_PERF_EN
         if (k == 0) begin
            chk("rb perf_i", perf_i_grants, 32'd0);
            chk("rb perf_d", perf_d_grants, 32'd0);
         end
`endif
         step();
      end
      mem_ready = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
